// File: rtl/event_unit_pkg.sv
// Shared constants for the event/sleep register block: register indices,
// ID-register layout, event-count limit and a helper to pack the ID word.
package event_unit_pkg;

  // Sleep-unit register indices (word index within the slave window)
  localparam logic [1:0] REG_SLP_CTRL   = 2'd0;
  localparam logic [1:0] REG_SLP_STATUS = 2'd1;

  // Event-unit register indices, decoded from PADDR[3:2]
  localparam logic [1:0] REG_EV_MASK    = 2'd0;
  localparam logic [1:0] REG_EV_PENDING = 2'd1;
  localparam logic [1:0] REG_EV_SET     = 2'd2;
  localparam logic [1:0] REG_EV_ID      = 2'd3;

  // Bit position of the valid flag inside the ID register
  localparam int ID_VALID_BIT = 31;

  // Upper bound on the number of event lines one unit can aggregate
  localparam int MAX_EVENTS = 32;

  // Pack {valid, zeros, 5-bit index} for the ID register read-back
  function automatic logic [31:0] ev_id_word(input logic valid, input logic [4:0] id);
    logic [31:0] word;
    word               = 32'd0;
    word[ID_VALID_BIT] = valid;
    word[4:0]          = id;
    return word;
  endfunction

endpackage

// File: rtl/event_wake_ctrl_if.sv
// APB slave bus bundle for the event wake controller.
interface event_wake_ctrl_if #(
  parameter int ADDR_WIDTH = 12
);
  logic [ADDR_WIDTH-1:0] PADDR;
  logic [31:0]           PWDATA;
  logic                  PWRITE;
  logic                  PSEL;
  logic                  PENABLE;
  logic [31:0]           PRDATA;
  logic                  PREADY;
  logic                  PSLVERR;

  modport master (
    output PADDR, PWDATA, PWRITE, PSEL, PENABLE,
    input  PRDATA, PREADY, PSLVERR
  );

  modport slave (
    input  PADDR, PWDATA, PWRITE, PSEL, PENABLE,
    output PRDATA, PREADY, PSLVERR
  );
endinterface

// File: rtl/event_prio_enc.sv
// Lowest-set-bit priority encoder: returns the index of the lowest set
// request bit and a valid flag; index is 0 when no bit is set.
module event_prio_enc #(
  parameter int WIDTH     = 32,
  parameter int IDX_WIDTH = 5
) (
  input  logic [WIDTH-1:0]     req,
  output logic [IDX_WIDTH-1:0] idx,
  output logic                 valid
);

  // Scan upward; the first set bit found is latched and later bits ignored
  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      if (req[i] && !valid) begin
        idx   = IDX_WIDTH'(i);
        valid = 1'b1;
      end else begin
        idx   = idx;
        valid = valid;
      end
    end
  end

endmodule

// File: rtl/event_wake_ctrl.sv
// Event/interrupt aggregator in front of the sleep unit. Hardware rising
// edges and software-set events accumulate in a pending register; masked
// pending events drive the wake level and a lowest-index-first IRQ with ack.
module event_wake_ctrl
  import event_unit_pkg::*;
#(
  parameter int APB_ADDR_WIDTH = 12,
  parameter int NUM_EVENTS     = 32,
  parameter int ID_WIDTH       = 5
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  event_wake_ctrl_if.slave      apb,
  input  logic [NUM_EVENTS-1:0] events_i,
  output logic                  wake_o,
  output logic                  irq_o,
  output logic [ID_WIDTH-1:0]   irq_id_o,
  input  logic                  irq_ack_i,
  input  logic [ID_WIDTH-1:0]   irq_ack_id_i
);

  logic [NUM_EVENTS-1:0] mask_q;
  logic [NUM_EVENTS-1:0] pend_q;
  logic [NUM_EVENTS-1:0] events_q;
  logic [NUM_EVENTS-1:0] rise;
  logic [NUM_EVENTS-1:0] apb_set;
  logic [NUM_EVENTS-1:0] apb_clr;
  logic [NUM_EVENTS-1:0] ack_clr;
  logic [NUM_EVENTS-1:0] pend_n;
  logic [NUM_EVENTS-1:0] active;
  logic                  mask_wr;
  logic                  apb_wr;
  logic                  apb_rd;
  logic [1:0]            reg_idx;
  logic                  enc_valid;
  logic [ID_WIDTH-1:0]   enc_idx;
  logic [31:0]           prdata;
  logic                  unused_apb;

  assign apb_wr  = apb.PSEL & apb.PENABLE & apb.PWRITE;
  assign apb_rd  = apb.PSEL & apb.PENABLE & ~apb.PWRITE;
  assign reg_idx = apb.PADDR[3:2];

  // Only a few address bits take part in decode; the rest are don't-care
  assign unused_apb = ^{apb.PADDR[APB_ADDR_WIDTH-1:0], apb.PWDATA};

  // Decode APB writes into mask load, software set and W1C clear strobes
  always_comb begin
    apb_set = '0;
    apb_clr = '0;
    mask_wr = 1'b0;
    if (apb_wr) begin
      case (reg_idx)
        REG_EV_MASK:    mask_wr = 1'b1;
        REG_EV_PENDING: apb_clr = apb.PWDATA[NUM_EVENTS-1:0];
        REG_EV_SET:     apb_set = apb.PWDATA[NUM_EVENTS-1:0];
        default:        mask_wr = 1'b0;
      endcase
    end else begin
      mask_wr = 1'b0;
    end
  end

  // One-hot clear from the core ack; ids beyond the event range match nothing
  always_comb begin
    ack_clr = '0;
    for (int i = 0; i < NUM_EVENTS; i++) begin
      if (irq_ack_i && (irq_ack_id_i == ID_WIDTH'(i))) begin
        ack_clr[i] = 1'b1;
      end else begin
        ack_clr[i] = 1'b0;
      end
    end
  end

  // Sets (edge or software) win over clears (W1C or ack) on the same bit
  assign rise   = events_i & ~events_q;
  assign pend_n = (pend_q & ~apb_clr & ~ack_clr) | rise | apb_set;
  assign active = pend_q & mask_q;

  // State registers: edge history, pending and mask, cleared by sync reset
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      events_q <= '0;
      pend_q   <= '0;
      mask_q   <= '0;
    end else begin
      events_q <= events_i;
      pend_q   <= pend_n;
      if (mask_wr) begin
        mask_q <= apb.PWDATA[NUM_EVENTS-1:0];
      end else begin
        mask_q <= mask_q;
      end
    end
  end

  event_prio_enc #(
    .WIDTH     (NUM_EVENTS),
    .IDX_WIDTH (ID_WIDTH)
  ) u_prio (
    .req   (active),
    .idx   (enc_idx),
    .valid (enc_valid)
  );

  assign wake_o   = |active;
  assign irq_o    = enc_valid;
  assign irq_id_o = enc_idx;

  // Read mux, driven only during the access phase of a read
  always_comb begin
    prdata = 32'd0;
    if (apb_rd) begin
      case (reg_idx)
        REG_EV_MASK:    prdata = 32'(MAX_EVENTS'(mask_q));
        REG_EV_PENDING: prdata = 32'(MAX_EVENTS'(pend_q));
        REG_EV_SET:     prdata = 32'd0;
        REG_EV_ID:      prdata = ev_id_word(irq_o, 5'(irq_id_o));
        default:        prdata = 32'd0;
      endcase
    end else begin
      prdata = 32'd0;
    end
  end

  assign apb.PRDATA  = prdata;
  assign apb.PREADY  = 1'b1;
  assign apb.PSLVERR = 1'b0;

endmodule

// File: tb/tb_event_wake_ctrl.sv
// Self-checking bench for event_wake_ctrl: directed vector table, multi-cycle
// corner sequences and randomized traffic against a behavioural model.
module tb_event_wake_ctrl;

  logic        HCLK;
  logic        HRESETn;
  logic [31:0] events;
  logic        ack;
  logic [4:0]  ack_id;
  logic        wake;
  logic        irq;
  logic [4:0]  irq_id;

  event_wake_ctrl_if #(.ADDR_WIDTH(12)) bus ();

  event_wake_ctrl #(
    .APB_ADDR_WIDTH (12),
    .NUM_EVENTS     (32),
    .ID_WIDTH       (5)
  ) dut (
    .HCLK         (HCLK),
    .HRESETn      (HRESETn),
    .apb          (bus),
    .events_i     (events),
    .wake_o       (wake),
    .irq_o        (irq),
    .irq_id_o     (irq_id),
    .irq_ack_i    (ack),
    .irq_ack_id_i (ack_id)
  );

  initial begin
    HCLK = 1'b0;
    forever #5 HCLK = ~HCLK;
  end

  int errors = 0;
  int checks = 0;

  // Behavioural model state
  bit [31:0] m_mask;
  bit [31:0] m_pend;
  bit [31:0] m_prev;
  bit        m_known = 1'b0;

  localparam logic [11:0] A_MASK = 12'h000;
  localparam logic [11:0] A_PEND = 12'h004;
  localparam logic [11:0] A_SET  = 12'h008;
  localparam logic [11:0] A_ID   = 12'h00C;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Expected outputs from the model: lowest masked pending index wins
  task automatic model_check();
    bit [31:0] act_set;
    bit        x_wake;
    bit [4:0]  x_id;
    bit [31:0] x_prd;
    act_set = m_pend & m_mask;
    x_wake  = (act_set != 32'd0);
    x_id    = 5'd0;
    for (int b = 31; b >= 0; b--) begin
      if (act_set[b]) x_id = 5'(b);
    end
    x_prd = 32'd0;
    if (bus.PSEL && bus.PENABLE && !bus.PWRITE) begin
      case (bus.PADDR[3:2])
        2'd0: x_prd = m_mask;
        2'd1: x_prd = m_pend;
        2'd2: x_prd = 32'd0;
        default: x_prd = {x_wake, 26'd0, x_id};
      endcase
    end
    chk("model_wake", {31'd0, wake}, {31'd0, x_wake});
    chk("model_irq", {31'd0, irq}, {31'd0, x_wake});
    chk("model_irq_id", {27'd0, irq_id}, {27'd0, x_id});
    chk("model_prdata", bus.PRDATA, x_prd);
    chk("model_pready", {31'd0, bus.PREADY}, 32'd1);
    chk("model_pslverr", {31'd0, bus.PSLVERR}, 32'd0);
  endtask

  task automatic drive(input logic r, input logic s, input logic w, input logic [11:0] a,
                       input logic [31:0] d, input logic [31:0] e, input logic k,
                       input logic [4:0] kid);
    HRESETn     = r;
    bus.PSEL    = s;
    bus.PENABLE = s;
    bus.PWRITE  = w;
    bus.PADDR   = a;
    bus.PWDATA  = d;
    events      = e;
    ack         = k;
    ack_id      = kid;
    #2;
    if (m_known) model_check();
  endtask

  // Advance one clock and update the model from the inputs held at the edge
  task automatic tick();
    bit wr_s;
    bit rose, swset, swclr, acked;
    @(posedge HCLK);
    wr_s = bus.PSEL && bus.PENABLE && bus.PWRITE;
    if (!HRESETn) begin
      m_mask  = 32'd0;
      m_pend  = 32'd0;
      m_prev  = 32'd0;
      m_known = 1'b1;
    end else begin
      for (int b = 0; b < 32; b++) begin
        rose  = events[b] && !m_prev[b];
        swset = wr_s && (bus.PADDR[3:2] == 2'd2) && bus.PWDATA[b];
        swclr = wr_s && (bus.PADDR[3:2] == 2'd1) && bus.PWDATA[b];
        acked = ack && (int'(ack_id) == b);
        if (rose || swset) m_pend[b] = 1'b1;
        else if (swclr || acked) m_pend[b] = 1'b0;
      end
      if (wr_s && bus.PADDR[3:2] == 2'd0) m_mask = bus.PWDATA;
      m_prev = events;
    end
    #1;
  endtask

  task automatic do_reset();
    drive(1'b0, 1'b0, 1'b0, A_MASK, 32'd0, 32'd0, 1'b0, 5'd0);
    tick();
  endtask

  typedef struct {
    logic        w;
    logic        s;
    logic [11:0] a;
    logic [31:0] d;
    logic [31:0] e;
    logic        k;
    logic [4:0]  kid;
    logic        x_wake;
    logic [4:0]  x_id;
    logic [31:0] x_prd;
  } vec_t;

  vec_t tbl[24];

  initial begin
    // w, s, addr, wdata, events, ack, ack_id | wake, id, prdata
    tbl[0]  = '{1'b0, 1'b0, A_MASK, 32'd0,          32'd0, 1'b0, 5'd0, 1'b0, 5'd0,  32'd0};
    tbl[1]  = '{1'b0, 1'b1, A_MASK, 32'd0,          32'd0, 1'b0, 5'd0, 1'b0, 5'd0,  32'd0};
    tbl[2]  = '{1'b1, 1'b1, A_MASK, 32'h5,          32'd0, 1'b0, 5'd0, 1'b0, 5'd0,  32'd0};
    tbl[3]  = '{1'b0, 1'b1, A_MASK, 32'd0,          32'h4, 1'b0, 5'd0, 1'b0, 5'd0,  32'h5};
    tbl[4]  = '{1'b0, 1'b1, A_PEND, 32'd0,          32'd0, 1'b0, 5'd0, 1'b1, 5'd2,  32'h4};
    tbl[5]  = '{1'b0, 1'b1, A_ID,   32'd0,          32'd0, 1'b0, 5'd0, 1'b1, 5'd2,  32'h8000_0002};
    tbl[6]  = '{1'b0, 1'b1, A_SET,  32'd0,          32'd0, 1'b0, 5'd0, 1'b1, 5'd2,  32'd0};
    tbl[7]  = '{1'b0, 1'b0, A_MASK, 32'd0,          32'd0, 1'b1, 5'd2, 1'b1, 5'd2,  32'd0};
    tbl[8]  = '{1'b0, 1'b0, A_MASK, 32'd0,          32'd0, 1'b0, 5'd0, 1'b0, 5'd0,  32'd0};
    tbl[9]  = '{1'b1, 1'b1, A_SET,  32'h8000_0000,  32'd0, 1'b0, 5'd0, 1'b0, 5'd0,  32'd0};
    tbl[10] = '{1'b0, 1'b1, A_PEND, 32'd0,          32'd0, 1'b0, 5'd0, 1'b0, 5'd0,  32'h8000_0000};
    tbl[11] = '{1'b1, 1'b1, A_MASK, 32'h8000_0000,  32'd0, 1'b0, 5'd0, 1'b0, 5'd0,  32'd0};
    tbl[12] = '{1'b0, 1'b1, A_ID,   32'd0,          32'd0, 1'b0, 5'd0, 1'b1, 5'd31, 32'h8000_001F};
    tbl[13] = '{1'b1, 1'b1, A_PEND, 32'h8000_0000,  32'h8, 1'b0, 5'd0, 1'b1, 5'd31, 32'd0};
    tbl[14] = '{1'b0, 1'b1, A_PEND, 32'd0,          32'd0, 1'b0, 5'd0, 1'b0, 5'd0,  32'h8};
    tbl[15] = '{1'b1, 1'b1, A_PEND, 32'h8,          32'h8, 1'b0, 5'd0, 1'b0, 5'd0,  32'd0};
    tbl[16] = '{1'b0, 1'b1, A_PEND, 32'd0,          32'd0, 1'b0, 5'd0, 1'b0, 5'd0,  32'h8};
    tbl[17] = '{1'b1, 1'b1, A_SET,  32'h3,          32'd0, 1'b0, 5'd0, 1'b0, 5'd0,  32'd0};
    tbl[18] = '{1'b1, 1'b1, A_MASK, 32'h3,          32'd0, 1'b0, 5'd0, 1'b0, 5'd0,  32'd0};
    tbl[19] = '{1'b0, 1'b1, A_PEND, 32'd0,          32'd0, 1'b0, 5'd0, 1'b1, 5'd0,  32'hB};
    tbl[20] = '{1'b1, 1'b1, A_PEND, 32'h1,          32'd0, 1'b1, 5'd1, 1'b1, 5'd0,  32'd0};
    tbl[21] = '{1'b0, 1'b1, A_PEND, 32'd0,          32'd0, 1'b0, 5'd0, 1'b0, 5'd0,  32'h8};
    tbl[22] = '{1'b0, 1'b0, A_MASK, 32'd0,          32'd0, 1'b1, 5'd5, 1'b0, 5'd0,  32'd0};
    tbl[23] = '{1'b0, 1'b1, A_PEND, 32'd0,          32'd0, 1'b0, 5'd0, 1'b0, 5'd0,  32'h8};

    events = 32'd0;
    ack    = 1'b0;
    ack_id = 5'd0;
    @(posedge HCLK);
    #1;
    do_reset();
    do_reset();

    // Directed vector table
    for (int i = 0; i < 24; i++) begin
      drive(1'b1, tbl[i].s, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].e, tbl[i].k, tbl[i].kid);
      chk($sformatf("tbl_wake[%0d]", i), {31'd0, wake}, {31'd0, tbl[i].x_wake});
      chk($sformatf("tbl_irq[%0d]", i), {31'd0, irq}, {31'd0, tbl[i].x_wake});
      chk($sformatf("tbl_id[%0d]", i), {27'd0, irq_id}, {27'd0, tbl[i].x_id});
      chk($sformatf("tbl_prdata[%0d]", i), bus.PRDATA, tbl[i].x_prd);
      tick();
    end

    // Line held high sets pending once; ack clears it while still high
    do_reset();
    drive(1'b1, 1'b1, 1'b1, A_MASK, 32'h1, 32'd0, 1'b0, 5'd0);
    tick();
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b1, 1'b0, A_PEND, 32'd0, 32'h1, (i == 3), 5'd0);
      chk($sformatf("hold_pend[%0d]", i), bus.PRDATA, (i >= 1 && i <= 3) ? 32'h1 : 32'h0);
      tick();
    end
    drive(1'b1, 1'b1, 1'b0, A_PEND, 32'd0, 32'h0, 1'b0, 5'd0);
    chk("hold_drop", bus.PRDATA, 32'h0);
    tick();
    drive(1'b1, 1'b1, 1'b0, A_PEND, 32'd0, 32'h1, 1'b0, 5'd0);
    chk("hold_reraise_same", bus.PRDATA, 32'h0);
    tick();
    drive(1'b1, 1'b1, 1'b0, A_PEND, 32'd0, 32'h1, 1'b0, 5'd0);
    chk("hold_reraise_next", bus.PRDATA, 32'h1);
    tick();

    // Ack walks the priority encoder from id 2 to id 4 to empty
    do_reset();
    drive(1'b1, 1'b1, 1'b1, A_MASK, 32'hFFFF_FFFF, 32'd0, 1'b0, 5'd0);
    tick();
    drive(1'b1, 1'b1, 1'b1, A_SET, 32'h14, 32'd0, 1'b0, 5'd0);
    tick();
    drive(1'b1, 1'b0, 1'b0, A_MASK, 32'd0, 32'd0, 1'b1, 5'd2);
    chk("ack_seq_id2", {27'd0, irq_id}, 32'd2);
    tick();
    drive(1'b1, 1'b0, 1'b0, A_MASK, 32'd0, 32'd0, 1'b1, 5'd4);
    chk("ack_seq_id4", {27'd0, irq_id}, 32'd4);
    chk("ack_seq_wake4", {31'd0, wake}, 32'd1);
    tick();
    drive(1'b1, 1'b0, 1'b0, A_MASK, 32'd0, 32'd0, 1'b0, 5'd0);
    chk("ack_seq_wake0", {31'd0, wake}, 32'd0);
    chk("ack_seq_irq0", {31'd0, irq}, 32'd0);
    tick();

    // Mid-operation reset clears state; a rise during reset is dropped
    drive(1'b1, 1'b1, 1'b1, A_SET, 32'hFF, 32'd0, 1'b0, 5'd0);
    tick();
    drive(1'b1, 1'b1, 1'b1, A_MASK, 32'hFF, 32'd0, 1'b0, 5'd0);
    tick();
    drive(1'b1, 1'b1, 1'b0, A_PEND, 32'd0, 32'd0, 1'b0, 5'd0);
    chk("rst_pre_pend", bus.PRDATA, 32'hFF);
    chk("rst_pre_wake", {31'd0, wake}, 32'd1);
    tick();
    drive(1'b0, 1'b0, 1'b0, A_MASK, 32'd0, 32'h0F00, 1'b0, 5'd0);
    tick();
    drive(1'b1, 1'b1, 1'b0, A_PEND, 32'd0, 32'd0, 1'b0, 5'd0);
    chk("rst_post_pend", bus.PRDATA, 32'h0);
    chk("rst_post_wake", {31'd0, wake}, 32'd0);
    tick();
    drive(1'b1, 1'b1, 1'b0, A_MASK, 32'd0, 32'd0, 1'b0, 5'd0);
    chk("rst_post_mask", bus.PRDATA, 32'h0);
    tick();

    // Randomized traffic checked against the model every cycle
    begin
      logic [31:0] ev;
      logic [31:0] d;
      ev = 32'd0;
      for (int n = 0; n < 600; n++) begin
        ev = ev ^ ($urandom & $urandom & $urandom);
        d  = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & $urandom & $urandom);
        drive(($urandom_range(0, 59) != 0), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), {8'd0, 2'($urandom_range(0, 3)), 2'b00},
              d, ev, ($urandom_range(0, 2) == 0), 5'($urandom_range(0, 31)));
        tick();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
